// File: rtl/pack_pkg.sv
// Constants and state encoding shared by the packet framer and deframer.
package pack_pkg;
    localparam int          SIZE_BIT_PACK  = 1976;
    localparam int          SIZE_PREAMBLE  = 32;
    localparam logic [31:0] PREAMBLE_DATA  = 32'h1ACFFC1D;
    localparam logic [31:0] PREAMBLE_BLANK = 32'hE53003E2;

    typedef enum logic [1:0] {
        SEARCH,
        PAYLOAD,
        SKIP,
        CHECK
    } deframe_state_t;
endpackage

// File: rtl/preamble_match.sv
// Tolerant preamble compare: hit when window and pattern differ in at most MAX_ERR bits.
// Purely combinational, no latency and no flow control.
module preamble_match #(
    parameter int W       = 32,
    parameter int MAX_ERR = 2
) (
    input  logic [W-1:0] window,
    input  logic [W-1:0] pattern,
    output logic         hit
);
    localparam int CNT_W = $clog2(W + 1);

    logic [W-1:0]     diff;
    logic [CNT_W-1:0] errs;

    always_comb begin
        diff = window ^ pattern;
        errs = '0;
        for (int i = 0; i < W; i++) begin
            errs = errs + CNT_W'(diff[i]);
        end
    end

    assign hit = (errs <= CNT_W'(MAX_ERR));
endmodule

// File: rtl/pack_deframer.sv
// Serial packet deframer: preamble search, flywheel lock, blank packets dropped, payload out as bytes.
// Byte valid one cycle after its last bit; input stalls while an output byte waits for i_ready_output.
module pack_deframer #(
    parameter int                       SIZE_BIT_PACK   = pack_pkg::SIZE_BIT_PACK,
    parameter int                       SIZE_PREAMBLE   = pack_pkg::SIZE_PREAMBLE,
    parameter int                       SIZE_OUTPUT_BIT = 8,
    parameter logic [SIZE_PREAMBLE-1:0] PREAMBLE_DATA   = pack_pkg::PREAMBLE_DATA,
    parameter logic [SIZE_PREAMBLE-1:0] PREAMBLE_BLANK  = pack_pkg::PREAMBLE_BLANK,
    parameter int                       MAX_ERR         = 2,
    parameter int                       MISS_LIMIT      = 3
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_data,
    input  logic                       i_valid_input,
    output logic                       o_ready,
    output logic [SIZE_OUTPUT_BIT-1:0] o_data,
    output logic                       o_valid,
    output logic                       o_sop,
    output logic                       o_eop,
    input  logic                       i_ready_output,
    output logic                       o_locked,
    output logic                       o_sync_lost
);
    import pack_pkg::deframe_state_t, pack_pkg::SEARCH, pack_pkg::PAYLOAD,
           pack_pkg::SKIP, pack_pkg::CHECK;

    localparam int NPAY = SIZE_BIT_PACK - SIZE_PREAMBLE;
    localparam int CW   = $clog2(NPAY);
    localparam int MW   = $clog2(MISS_LIMIT + 1);

    localparam logic [CW-1:0] LAST_PAY  = CW'(NPAY - 1);
    localparam logic [CW-1:0] LAST_PRE  = CW'(SIZE_PREAMBLE - 1);
    localparam logic [CW-1:0] FIRST_BYTE_END = CW'(SIZE_OUTPUT_BIT - 1);
    localparam logic [CW-1:0] BYTE_BITS = CW'(SIZE_OUTPUT_BIT);
    localparam logic [MW-1:0] LAST_MISS = MW'(MISS_LIMIT - 1);

    if ((NPAY % SIZE_OUTPUT_BIT) != 0) begin : g_npay_check
        $error("payload length must be a whole number of output words");
    end

    deframe_state_t             state;
    logic [SIZE_PREAMBLE-1:0]   sr;
    logic [SIZE_PREAMBLE-1:0]   win;
    logic [CW-1:0]              bit_cnt;
    logic [MW-1:0]              miss_cnt;
    logic [SIZE_OUTPUT_BIT-1:0] byte_sr;
    logic [SIZE_OUTPUT_BIT-1:0] byte_nxt;
    logic                       acc;
    logic                       hit_d;
    logic                       hit_b;
    logic                       byte_done;
    logic                       last_pay;
    logic                       last_pre;

    // An unaccepted byte blocks input; a new byte needs 8 more accepted bits, so no overflow.
    assign o_ready   = ~(o_valid & ~i_ready_output);
    assign acc       = i_valid_input & o_ready;
    assign win       = {sr[SIZE_PREAMBLE-2:0], i_data};
    assign byte_nxt  = {byte_sr[SIZE_OUTPUT_BIT-2:0], i_data};
    assign byte_done = ((bit_cnt % BYTE_BITS) == FIRST_BYTE_END);
    assign last_pay  = (bit_cnt == LAST_PAY);
    assign last_pre  = (bit_cnt == LAST_PRE);

    preamble_match #(.W(SIZE_PREAMBLE), .MAX_ERR(MAX_ERR)) u_match_data (
        .window  (win),
        .pattern (PREAMBLE_DATA),
        .hit     (hit_d)
    );

    preamble_match #(.W(SIZE_PREAMBLE), .MAX_ERR(MAX_ERR)) u_match_blank (
        .window  (win),
        .pattern (PREAMBLE_BLANK),
        .hit     (hit_b)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= SEARCH;
            sr          <= '0;
            bit_cnt     <= '0;
            miss_cnt    <= '0;
            byte_sr     <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_sop       <= 1'b0;
            o_eop       <= 1'b0;
            o_locked    <= 1'b0;
            o_sync_lost <= 1'b0;
        end else begin
            o_sync_lost <= 1'b0;
            if (o_valid && i_ready_output) begin
                o_valid <= 1'b0;
            end
            if (acc) begin
                sr <= win;
                case (state)
                    SEARCH: begin
                        if (hit_d || hit_b) begin
                            state    <= hit_d ? PAYLOAD : SKIP;
                            o_locked <= 1'b1;
                            bit_cnt  <= '0;
                            miss_cnt <= '0;
                        end
                    end
                    PAYLOAD: begin
                        byte_sr <= byte_nxt;
                        if (byte_done) begin
                            o_data  <= byte_nxt;
                            o_valid <= 1'b1;
                            o_sop   <= (bit_cnt == FIRST_BYTE_END);
                            o_eop   <= last_pay;
                        end
                        if (last_pay) begin
                            state   <= CHECK;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    SKIP: begin
                        if (last_pay) begin
                            state   <= CHECK;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    CHECK: begin
                        if (last_pre) begin
                            bit_cnt <= '0;
                            if (hit_d) begin
                                state    <= PAYLOAD;
                                miss_cnt <= '0;
                            end else if (hit_b) begin
                                state    <= SKIP;
                                miss_cnt <= '0;
                            end else if (miss_cnt == LAST_MISS) begin
                                state       <= SEARCH;
                                miss_cnt    <= '0;
                                o_locked    <= 1'b0;
                                o_sync_lost <= 1'b1;
                            end else begin
                                // Flywheel: a damaged preamble is assumed to precede data.
                                state    <= PAYLOAD;
                                miss_cnt <= miss_cnt + 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end
endmodule
